payload_packer: RTL and testbench
=================================

Name: payload_packer

Overview:
- Transmit-side counterpart of the payload aligner: merges Header A, Header B, Header C and an aligned payload stream into one packet stream (valid/data/sop/eop/byte_enable), ready to drive a packet_intf source.
- Headers are captured on the payload SOP beat and emitted first.
- Payload is shifted across beat boundaries behind the 14-byte header, with a flush beat when needed.
- Ready/valid backpressure on both sides.

Parameters:
- DATA_BYTES, default 8: bus width in bytes. Constraint: DATA_BYTES < HDR_TOTAL_BYTES < 2*DATA_BYTES.

Ports:
- iClk  in  1  clock.
- iReset  in  1  reset, asynchronous, active-high.
- iHeader_A  in  HDR_A_BYTES*8  Header A, byte 0 in the MS byte.
- iHeader_A_valid  in  1  Header A present.
- iHeader_B  in  HDR_B_BYTES*8  Header B.
- iHeader_B_valid  in  1  Header B present.
- iHeader_C  in  HDR_C_BYTES*8  Header C.
- iHeader_C_valid  in  1  Header C present.
- iPayload  in  DATA_BYTES*8  payload beat, lane 0 = [8*DATA_BYTES-1 -: 8].
- iPayload_valid  in  1  payload beat valid.
- iSop  in  1  first payload beat.
- iEop  in  1  last payload beat.
- iByte_enable  in  DATA_BYTES  lane enables, contiguous from lane 0; all-ones unless iEop.
- oReady  out  1  payload beat accepted when iPayload_valid && oReady.
- oValid  out  1  output beat valid.
- oPacket  out  DATA_BYTES*8  output beat.
- oSop  out  1  first packet beat.
- oEop  out  1  last packet beat.
- oByte_enable  out  DATA_BYTES  output lane enables.
- iReady  in  1  downstream accepts the output beat when oValid && iReady.

Behaviour:
- Reset (async, while iReset=1): state IDLE; oValid, oSop, oEop, oPacket, oByte_enable all 0; oReady=0; residual and header buffers 0.
- Output register advances (adv) when !oValid || iReady; otherwise all outputs hold stable.
- Define H=HDR_TOTAL_BYTES (14), K=2*DATA_BYTES-H (payload bytes in beat 1; 2), R=H-DATA_BYTES (carried residual; 6). n = popcount(iByte_enable).
- IDLE:
  - oReady=adv.
  - Non-SOP beats are accepted and dropped.
  - On SOP accept: latch the 14 header bytes and the payload beat (with its eop and n).
  - Emit beat 0 = header bytes 0..7, oSop=1, BE all-ones.
  - Go HDR1.
- HDR1:
  - oReady=0.
  - On adv: emit header bytes 8..13 plus held payload bytes 0..K-1.
  - Residual = held bytes K..7.
  - If held eop and n<=K: oEop=1, BE = first 6+n lanes, go IDLE.
  - Else if held eop: go TAIL with residual count n-K.
  - Else: go BODY.
- BODY:
  - oReady=adv.
  - On accept: emit residual(R) plus new bytes 0..K-1; residual = new bytes K..7.
  - Eop with n<=K: oEop=1, BE = R+n lanes, go IDLE.
  - Eop with n>K: go TAIL.
- TAIL:
  - oReady=0.
  - On adv: emit residual (n-K bytes, left-justified), oEop=1, BE accordingly, go IDLE.
- Latency: first output beat is 1 cycle after SOP accept. Throughput: one beat per cycle in BODY.
- Header valids are only sampled on the SOP accept. A header with valid=0 is emitted as zeros.
- Disabled output lanes drive 0.
- SOP during BODY is treated as a payload beat (checked only with the optional feature).
- Single-beat payload with n=8 -> 3 output beats (HDR0, HDR1, TAIL).
- Reset mid-packet: immediate return to reset values; partial packet is discarded.

Optional Feature:
- Macro PAYLOAD_PACKER_ERR_EN.
- Defined: adds output oError (1 bit), sticky until reset. Set the cycle after any of:
  - SOP accepted in BODY;
  - SOP accepted with any header valid=0;
  - non-contiguous iByte_enable;
  - iByte_enable not all-ones on a non-EOP beat.
  The datapath is unaffected.
- Undefined: no oError port, no checking logic.

Decomposition:
- packet_pkg additions:
  - HDR_A_BYTES=4, HDR_B_BYTES=6, HDR_C_BYTES=4, HDR_TOTAL_BYTES;
  - typedefs header_a_t, header_b_t, header_c_t;
  - enum packer_state_t {IDLE, HDR1, BODY, TAIL};
  - function be_from_count(n).
- Sub-module: packer_shifter (combinational), which concatenates residual and new bytes and produces data plus BE for a given count.

Test Plan:
- 1: Headers A=0x01020304, B=0x05060708090A, C=0x0B0C0D0E; one 8-byte payload beat 0x10..0x17 with sop+eop -> three output beats:
  - 0x0102030405060708 sop BE=0xFF;
  - 0x090A0B0C0D0E1011 BE=0xFF;
  - 0x1213141516170000 eop BE=0xFC.
- 2: 26-byte payload (4 beats, last n=2) -> 5 output beats; the last beat is eop with BE=0xFF; bytes match a reference model.
- 3: Payload n=1 single beat -> 2 beats; second beat eop with BE=0xFE (header 8..13 plus one payload byte).
- 4: iReady toggled 1010 during a 26-byte packet -> oPacket/oSop/oEop held while !iReady; the output sequence is identical to test 2.
- 5: iReset asserted mid-BODY -> outputs 0 the same cycle; the next SOP packet emits correctly.
- 6 (PAYLOAD_PACKER_ERR_EN): SOP during BODY -> oError=1 the next cycle and held until reset.

Source files
------------

// File: rtl/payload_packer_pkg.sv
// rtl/payload_packer_pkg.sv - shared constants, header types, FSM states and lane-enable helper for payload_packer
//
// Contents:
//   HDR_A_BYTES / HDR_B_BYTES / HDR_C_BYTES / HDR_TOTAL_BYTES : header sizes in bytes
//   header_a_t / header_b_t / header_c_t                      : header vectors, byte 0 in the MS byte
//   packer_state_t                                            : IDLE, HDR1, BODY, TAIL
//   be_from_count(n, width)                                   : first n lanes enabled, lane 0 = bit width-1
package payload_packer_pkg;

    localparam int HDR_A_BYTES     = 4;
    localparam int HDR_B_BYTES     = 6;
    localparam int HDR_C_BYTES     = 4;
    localparam int HDR_TOTAL_BYTES = HDR_A_BYTES + HDR_B_BYTES + HDR_C_BYTES;

    // Widest bus the lane-enable helper can describe; callers size-cast the result down.
    localparam int BE_MAX = 64;

    typedef logic [HDR_A_BYTES*8-1:0] header_a_t;
    typedef logic [HDR_B_BYTES*8-1:0] header_b_t;
    typedef logic [HDR_C_BYTES*8-1:0] header_c_t;

    typedef enum logic [1:0] {
        IDLE,
        HDR1,
        BODY,
        TAIL
    } packer_state_t;

    // Enables are contiguous from lane 0, and lane 0 sits in the MS bit, so the
    // mask is a run of ones left-justified within the low `width` bits.
    function automatic logic [BE_MAX-1:0] be_from_count(input int unsigned n, input int unsigned width);
        logic [BE_MAX-1:0] ones;
        int unsigned       lanes;
        ones  = '1;
        lanes = (n > width) ? width : n;
        if (lanes == 0) begin
            return '0;
        end
        return (ones << (BE_MAX - lanes)) >> (BE_MAX - width);
    endfunction

endpackage

// File: rtl/payload_packer_shifter.sv
// rtl/payload_packer_shifter.sv - joins carried bytes with the head of a new beat and masks to a byte count
//
// Ports:
//   carry    in  RES_BYTES*8   bytes emitted first (header tail or residual), left-justified
//   incoming in  DATA_BYTES*8  new beat; its first DATA_BYTES-RES_BYTES bytes complete the output
//   count    in  CW            number of valid output lanes, from lane 0
//   data     out DATA_BYTES*8  joined beat with lanes at or beyond count forced to zero
//   be       out DATA_BYTES    lane enables for count
//   rest     out RES_BYTES*8   tail of incoming that carries into the next beat
module payload_packer_shifter
    import payload_packer_pkg::*;
#(
    parameter int DATA_BYTES = 8,
    parameter int RES_BYTES  = 6,
    parameter int CW         = 4
) (
    input  logic [RES_BYTES*8-1:0]  carry,
    input  logic [DATA_BYTES*8-1:0] incoming,
    input  logic [CW-1:0]           count,
    output logic [DATA_BYTES*8-1:0] data,
    output logic [DATA_BYTES-1:0]   be,
    output logic [RES_BYTES*8-1:0]  rest
);

    localparam int K = DATA_BYTES - RES_BYTES;

    logic [DATA_BYTES*8-1:0] joined;
    logic [DATA_BYTES*8-1:0] mask;

    always_comb begin
        joined = {carry, incoming[DATA_BYTES*8-1 -: K*8]};
        be     = DATA_BYTES'(be_from_count(32'(count), DATA_BYTES));
        mask   = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        data = joined & mask;
        rest = incoming[RES_BYTES*8-1:0];
    end

endmodule

// File: rtl/payload_packer.sv
// rtl/payload_packer.sv - merges headers A/B/C and an aligned payload stream into one packet stream
//
// Optional build macro: PAYLOAD_PACKER_ERR_EN adds a sticky oError output.
//
// Ports:
//   iClk, iReset                    clock, asynchronous active-high reset
//   iHeader_A/B/C, *_valid          headers, sampled only when the payload SOP beat is accepted
//   iPayload, iPayload_valid, iSop, iEop, iByte_enable, oReady
//                                   payload input stream, lane 0 in the MS byte
//   oValid, oPacket, oSop, oEop, oByte_enable, iReady
//                                   registered packet output stream
//   oError (PAYLOAD_PACKER_ERR_EN)  sticky protocol error flag
module payload_packer
    import payload_packer_pkg::*;
#(
    parameter int DATA_BYTES = 8
) (
    input  logic                    iClk,
    input  logic                    iReset,
    input  header_a_t               iHeader_A,
    input  logic                    iHeader_A_valid,
    input  header_b_t               iHeader_B,
    input  logic                    iHeader_B_valid,
    input  header_c_t               iHeader_C,
    input  logic                    iHeader_C_valid,
    input  logic [DATA_BYTES*8-1:0] iPayload,
    input  logic                    iPayload_valid,
    input  logic                    iSop,
    input  logic                    iEop,
    input  logic [DATA_BYTES-1:0]   iByte_enable,
    output logic                    oReady,
    output logic                    oValid,
    output logic [DATA_BYTES*8-1:0] oPacket,
    output logic                    oSop,
    output logic                    oEop,
    output logic [DATA_BYTES-1:0]   oByte_enable,
    input  logic                    iReady
`ifdef PAYLOAD_PACKER_ERR_EN
    ,
    output logic                    oError
`endif
);

    localparam int H  = HDR_TOTAL_BYTES;
    localparam int K  = 2*DATA_BYTES - H;   // payload bytes that fit behind the header in beat 1
    localparam int R  = H - DATA_BYTES;     // bytes carried from one beat into the next
    localparam int CW = $clog2(DATA_BYTES + 1);

    localparam logic [CW-1:0] K_C = CW'(K);
    localparam logic [CW-1:0] R_C = CW'(R);
    localparam logic [CW-1:0] D_C = CW'(DATA_BYTES);

    packer_state_t           state;
    logic [R*8-1:0]          hdr_tail;      // header bytes DATA_BYTES..H-1
    logic [DATA_BYTES*8-1:0] held;          // SOP beat, emitted one beat later behind the header
    logic                    held_eop;
    logic [CW-1:0]           held_n;
    logic [R*8-1:0]          residual;
    logic [CW-1:0]           rcount;

    logic                    adv;
    logic                    accept;
    logic [CW-1:0]           n_in;
    header_a_t               hdr_a;
    header_b_t               hdr_b;
    header_c_t               hdr_c;
    logic [H*8-1:0]          hdr_in;

    logic [R*8-1:0]          sh_carry;
    logic [DATA_BYTES*8-1:0] sh_incoming;
    logic [CW-1:0]           sh_count;
    logic [DATA_BYTES*8-1:0] sh_data;
    logic [DATA_BYTES-1:0]   sh_be;
    logic [R*8-1:0]          sh_rest;
    logic                    sel_eop;
    logic [CW-1:0]           sel_n;
    logic                    short_end;

    assign adv    = !oValid || iReady;
    // Gating with iReset keeps oReady low while reset is held, even though the
    // cleared output register would otherwise look ready.
    assign oReady = !iReset && adv && (state == IDLE || state == BODY);
    assign accept = iPayload_valid && oReady;
    assign n_in   = CW'($countones(iByte_enable));

    always_comb begin
        hdr_a  = iHeader_A_valid ? iHeader_A : '0;
        hdr_b  = iHeader_B_valid ? iHeader_B : '0;
        hdr_c  = iHeader_C_valid ? iHeader_C : '0;
        hdr_in = {hdr_a, hdr_b, hdr_c};
    end

    // One shifter serves HDR1, BODY and TAIL; only its carry/incoming sources differ.
    always_comb begin
        sh_carry    = residual;
        sh_incoming = iPayload;
        sel_eop     = iEop;
        sel_n       = n_in;
        case (state)
            HDR1: begin
                sh_carry    = hdr_tail;
                sh_incoming = held;
                sel_eop     = held_eop;
                sel_n       = held_n;
            end
            TAIL: begin
                sh_incoming = '0;
                sel_eop     = 1'b1;
                sel_n       = rcount;
            end
            default: begin
            end
        endcase
        // short_end: the last payload bytes fit in the current output beat, no TAIL needed.
        short_end = sel_eop && (sel_n <= K_C);
        if (state == TAIL) begin
            sh_count = rcount;
        end else if (short_end) begin
            sh_count = R_C + sel_n;
        end else begin
            sh_count = D_C;
        end
    end

    payload_packer_shifter #(
        .DATA_BYTES (DATA_BYTES),
        .RES_BYTES  (R),
        .CW         (CW)
    ) u_shifter (
        .carry    (sh_carry),
        .incoming (sh_incoming),
        .count    (sh_count),
        .data     (sh_data),
        .be       (sh_be),
        .rest     (sh_rest)
    );

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state        <= IDLE;
            hdr_tail     <= '0;
            held         <= '0;
            held_eop     <= 1'b0;
            held_n       <= '0;
            residual     <= '0;
            rcount       <= '0;
            oValid       <= 1'b0;
            oPacket      <= '0;
            oSop         <= 1'b0;
            oEop         <= 1'b0;
            oByte_enable <= '0;
        end else if (adv) begin
            // Beat consumed (or register empty): clear unless a new beat is produced below.
            oValid       <= 1'b0;
            oPacket      <= '0;
            oSop         <= 1'b0;
            oEop         <= 1'b0;
            oByte_enable <= '0;
            case (state)
                IDLE: begin
                    // Non-SOP beats are accepted here and silently dropped.
                    if (accept && iSop) begin
                        hdr_tail     <= hdr_in[R*8-1:0];
                        held         <= iPayload;
                        held_eop     <= iEop;
                        held_n       <= n_in;
                        oValid       <= 1'b1;
                        oSop         <= 1'b1;
                        oPacket      <= hdr_in[H*8-1 -: DATA_BYTES*8];
                        oByte_enable <= '1;
                        state        <= HDR1;
                    end
                end
                HDR1: begin
                    oValid       <= 1'b1;
                    oPacket      <= sh_data;
                    oByte_enable <= sh_be;
                    oEop         <= short_end;
                    residual     <= sh_rest;
                    rcount       <= held_n - K_C;
                    state        <= short_end ? IDLE : (held_eop ? TAIL : BODY);
                end
                BODY: begin
                    if (accept) begin
                        oValid       <= 1'b1;
                        oPacket      <= sh_data;
                        oByte_enable <= sh_be;
                        oEop         <= short_end;
                        residual     <= sh_rest;
                        rcount       <= n_in - K_C;
                        state        <= short_end ? IDLE : (iEop ? TAIL : BODY);
                    end
                end
                TAIL: begin
                    oValid       <= 1'b1;
                    oPacket      <= sh_data;
                    oByte_enable <= sh_be;
                    oEop         <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PAYLOAD_PACKER_ERR_EN
    logic err_set;

    always_comb begin
        err_set = 1'b0;
        if (accept) begin
            if (iSop && state == BODY) begin
                err_set = 1'b1;
            end
            if (iSop && state == IDLE && !(iHeader_A_valid && iHeader_B_valid && iHeader_C_valid)) begin
                err_set = 1'b1;
            end
            if (iByte_enable != DATA_BYTES'(be_from_count(32'(n_in), DATA_BYTES))) begin
                err_set = 1'b1;
            end
            if (!iEop && iByte_enable != '1) begin
                err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            oError <= 1'b0;
        end else if (err_set) begin
            oError <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_payload_packer.sv
// tb/tb_payload_packer.sv - self-checking bench for payload_packer against a byte-list packet model
module tb_payload_packer;
    import payload_packer_pkg::*;

    localparam int D  = 8;
    localparam int BW = D*8 + 2 + D;   // {data, sop, eop, be}

    typedef logic [BW-1:0] beat_t;

    logic          iClk;
    logic          iReset;
    header_a_t     iHeader_A;
    logic          iHeader_A_valid;
    header_b_t     iHeader_B;
    logic          iHeader_B_valid;
    header_c_t     iHeader_C;
    logic          iHeader_C_valid;
    logic [D*8-1:0] iPayload;
    logic          iPayload_valid;
    logic          iSop;
    logic          iEop;
    logic [D-1:0]  iByte_enable;
    logic          oReady;
    logic          oValid;
    logic [D*8-1:0] oPacket;
    logic          oSop;
    logic          oEop;
    logic [D-1:0]  oByte_enable;
    logic          iReady;
`ifdef PAYLOAD_PACKER_ERR_EN
    logic          oError;
`endif

    payload_packer #(.DATA_BYTES(D)) dut (
        .iClk            (iClk),
        .iReset          (iReset),
        .iHeader_A       (iHeader_A),
        .iHeader_A_valid (iHeader_A_valid),
        .iHeader_B       (iHeader_B),
        .iHeader_B_valid (iHeader_B_valid),
        .iHeader_C       (iHeader_C),
        .iHeader_C_valid (iHeader_C_valid),
        .iPayload        (iPayload),
        .iPayload_valid  (iPayload_valid),
        .iSop            (iSop),
        .iEop            (iEop),
        .iByte_enable    (iByte_enable),
        .oReady          (oReady),
        .oValid          (oValid),
        .oPacket         (oPacket),
        .oSop            (oSop),
        .oEop            (oEop),
        .oByte_enable    (oByte_enable),
        .iReady          (iReady)
`ifdef PAYLOAD_PACKER_ERR_EN
        ,
        .oError          (oError)
`endif
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int          checks   = 0;
    int          failures = 0;
    int          ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
    beat_t       exp_q[$];
    beat_t       got_q[$];
    logic [7:0]  pl[$];
    logic [7:0]  pl_saved[$];
    beat_t       cur;
    logic [BW:0] prev_out;
    logic        prev_stall = 1'b0;

    assign cur = {oPacket, oSop, oEop, oByte_enable};

    // Output monitor: collects handshaken beats and checks that a stalled beat holds.
    always @(negedge iClk) begin
        if (iReset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                assert ({oValid, cur} === prev_out)
                else begin
                    failures++;
                    $error("FAIL hold_stable got=%h exp=%h", {oValid, cur}, prev_out);
                end
            end
            if (oValid && iReady) got_q.push_back(cur);
            prev_stall = oValid && !iReady;
            prev_out   = {oValid, cur};
        end
    end

    initial begin
        iReady = 1'b1;
        forever begin
            @(posedge iClk);
            #1;
            case (ready_mode)
                0:       iReady = 1'b1;
                1:       iReady = ~iReady;
                default: iReady = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Reference: the packet is the header byte list followed by the payload,
    // cut into D-byte beats; the final beat enables only the bytes present.
    task automatic model_packet(input header_a_t a, input logic av, input header_b_t b, input logic bv,
                                input header_c_t c, input logic cv);
        logic [7:0]    all[$];
        logic [D*8-1:0] data;
        logic [D-1:0]  be;
        int            nb;
        all = {};
        for (int i = 0; i < HDR_A_BYTES; i++) all.push_back(av ? a[HDR_A_BYTES*8-1-8*i -: 8] : 8'h00);
        for (int i = 0; i < HDR_B_BYTES; i++) all.push_back(bv ? b[HDR_B_BYTES*8-1-8*i -: 8] : 8'h00);
        for (int i = 0; i < HDR_C_BYTES; i++) all.push_back(cv ? c[HDR_C_BYTES*8-1-8*i -: 8] : 8'h00);
        foreach (pl[i]) all.push_back(pl[i]);
        nb = (all.size() + D - 1) / D;
        for (int bi = 0; bi < nb; bi++) begin
            data = '0;
            be   = '0;
            for (int l = 0; l < D; l++) begin
                if (bi*D + l < all.size()) begin
                    data[D*8-1-8*l -: 8] = all[bi*D + l];
                    be[D-1-l]            = 1'b1;
                end
            end
            exp_q.push_back({data, bi == 0, bi == nb - 1, be});
        end
    endtask

    task automatic send_beat(input logic [D*8-1:0] data, input logic sop, input logic eop, input logic [D-1:0] be);
        logic acc;
        int   budget;
        iPayload       = data;
        iPayload_valid = 1'b1;
        iSop           = sop;
        iEop           = eop;
        iByte_enable   = be;
        acc    = 1'b0;
        budget = 0;
        while (!acc) begin
            @(negedge iClk);
            acc = oReady;
            @(posedge iClk);
            #1;
            budget++;
            if (!acc && budget > 200) begin
                checks++;
                assert (acc === 1'b1)
                else begin
                    failures++;
                    $error("FAIL accept_timeout got=%0b exp=1", acc);
                end
                break;
            end
        end
    endtask

    task automatic idle_inputs();
        iPayload_valid = 1'b0;
        iSop           = 1'b0;
        iEop           = 1'b0;
        iPayload       = '0;
        iByte_enable   = '0;
    endtask

    task automatic send_packet(input header_a_t a, input logic av, input header_b_t b, input logic bv,
                               input header_c_t c, input logic cv);
        logic [D*8-1:0] data;
        logic [D-1:0]   be;
        int             nb;
        model_packet(a, av, b, bv, c, cv);
        iHeader_A = a; iHeader_A_valid = av;
        iHeader_B = b; iHeader_B_valid = bv;
        iHeader_C = c; iHeader_C_valid = cv;
        nb = (pl.size() + D - 1) / D;
        for (int bi = 0; bi < nb; bi++) begin
            data = '0;
            be   = '0;
            for (int l = 0; l < D; l++) begin
                if (bi*D + l < pl.size()) begin
                    data[D*8-1-8*l -: 8] = pl[bi*D + l];
                    be[D-1-l]            = 1'b1;
                end
            end
            send_beat(data, bi == 0, bi == nb - 1, be);
            if (bi == 0) begin
                // Headers must have been captured on the SOP beat; scramble them afterwards.
                iHeader_A = header_a_t'($urandom); iHeader_A_valid = 1'($urandom);
                iHeader_B = {16'($urandom), 32'($urandom)}; iHeader_B_valid = 1'($urandom);
                iHeader_C = header_c_t'($urandom); iHeader_C_valid = 1'($urandom);
            end
        end
        idle_inputs();
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (got_q.size() < exp_q.size() && budget < 400) begin
            @(posedge iClk);
            budget++;
        end
        repeat (6) @(posedge iClk);
        #1;
    endtask

    task automatic compare_model(input string tag);
        int n;
        checks++;
        assert (got_q.size() === exp_q.size())
        else begin
            failures++;
            $error("FAIL %s beat_count got=%0d exp=%0d", tag, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            assert (got_q[i] === exp_q[i])
            else begin
                failures++;
                $error("FAIL %s beat%0d got=%h exp=%h", tag, i, got_q[i], exp_q[i]);
            end
        end
        got_q = {};
        exp_q = {};
    endtask

    task automatic fill_random(input int len);
        pl = {};
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    endtask

    initial begin
        header_a_t ha;
        header_b_t hb;
        header_c_t hc;
        logic      hv;
        int        len;

        iReset = 1'b1;
        iHeader_A = '0; iHeader_A_valid = 1'b0;
        iHeader_B = '0; iHeader_B_valid = 1'b0;
        iHeader_C = '0; iHeader_C_valid = 1'b0;
        idle_inputs();
        repeat (3) @(posedge iClk);
        #1;
        checks++;
        assert ({oValid, oSop, oEop, oReady, oPacket, oByte_enable} === '0)
        else begin
            failures++;
            $error("FAIL reset_outputs got=%h exp=0", {oValid, oSop, oEop, oReady, oPacket, oByte_enable});
        end
        iReset = 1'b0;
        @(posedge iClk);
        #1;

        // Test 1: single full beat with sop+eop -> HDR0, HDR1, TAIL.
        pl = {};
        for (int i = 0; i < 8; i++) pl.push_back(8'h10 + 8'(i));
        send_packet(32'h01020304, 1'b1, 48'h05060708090A, 1'b1, 32'h0B0C0D0E, 1'b1);
        wait_drain();
        checks++;
        assert (got_q[0] === {64'h0102030405060708, 1'b1, 1'b0, 8'hFF})
        else begin failures++; $error("FAIL t1_beat0 got=%h exp=%h", got_q[0], {64'h0102030405060708, 1'b1, 1'b0, 8'hFF}); end
        checks++;
        assert (got_q[1] === {64'h090A0B0C0D0E1011, 1'b0, 1'b0, 8'hFF})
        else begin failures++; $error("FAIL t1_beat1 got=%h exp=%h", got_q[1], {64'h090A0B0C0D0E1011, 1'b0, 1'b0, 8'hFF}); end
        checks++;
        assert (got_q[2] === {64'h1213141516170000, 1'b0, 1'b1, 8'hFC})
        else begin failures++; $error("FAIL t1_beat2 got=%h exp=%h", got_q[2], {64'h1213141516170000, 1'b0, 1'b1, 8'hFC}); end
        compare_model("t1");

        // Test 2: 26-byte payload -> 5 beats, last one full with eop.
        ha = header_a_t'($urandom);
        hb = {16'($urandom), 32'($urandom)};
        hc = header_c_t'($urandom);
        fill_random(26);
        pl_saved = pl;
        send_packet(ha, 1'b1, hb, 1'b1, hc, 1'b1);
        wait_drain();
        checks++;
        assert (got_q.size() === 5)
        else begin failures++; $error("FAIL t2_count got=%0d exp=5", got_q.size()); end
        checks++;
        assert (got_q[4][D:0] === {1'b1, 8'hFF})
        else begin failures++; $error("FAIL t2_last_eop_be got=%h exp=%h", got_q[4][D:0], {1'b1, 8'hFF}); end
        compare_model("t2");

        // Test 3: one payload byte -> 2 beats, second eop with BE=0xFE.
        fill_random(1);
        send_packet(header_a_t'($urandom), 1'b1, {16'($urandom), 32'($urandom)}, 1'b1, header_c_t'($urandom), 1'b1);
        wait_drain();
        checks++;
        assert (got_q.size() === 2)
        else begin failures++; $error("FAIL t3_count got=%0d exp=2", got_q.size()); end
        checks++;
        assert (got_q[1][D:0] === {1'b1, 8'hFE})
        else begin failures++; $error("FAIL t3_last_eop_be got=%h exp=%h", got_q[1][D:0], {1'b1, 8'hFE}); end
        compare_model("t3");

        // Test 4: test 2 repeated with iReady toggling.
        ready_mode = 1;
        pl = pl_saved;
        send_packet(ha, 1'b1, hb, 1'b1, hc, 1'b1);
        wait_drain();
        compare_model("t4");
        ready_mode = 0;
        repeat (2) @(posedge iClk);
        #1;

        // Test 5: reset in BODY, then a dropped non-SOP beat, then a clean packet.
        send_beat({8{8'hA5}}, 1'b1, 1'b0, 8'hFF);
        send_beat({8{8'h5A}}, 1'b0, 1'b0, 8'hFF);
        send_beat({8{8'h3C}}, 1'b0, 1'b0, 8'hFF);
        idle_inputs();
        #2;
        iReset = 1'b1;
        #1;
        checks++;
        assert ({oValid, oSop, oEop, oReady, oPacket, oByte_enable} === '0)
        else begin
            failures++;
            $error("FAIL t5_reset_outputs got=%h exp=0", {oValid, oSop, oEop, oReady, oPacket, oByte_enable});
        end
        repeat (2) @(posedge iClk);
        #1;
        iReset = 1'b0;
        got_q = {};
        exp_q = {};
        @(posedge iClk);
        #1;
        send_beat({8{8'hEE}}, 1'b0, 1'b1, 8'hF0);
        idle_inputs();
        fill_random(20);
        send_packet(header_a_t'($urandom), 1'b1, {16'($urandom), 32'($urandom)}, 1'b0, header_c_t'($urandom), 1'b1);
        wait_drain();
        compare_model("t5");

        // Randomized packets: lengths, header valids and backpressure.
        for (int p = 0; p < 25; p++) begin
            ready_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            len = $urandom_range(1, 40);
            fill_random(len);
            hv = ($urandom_range(0, 4) != 0);
            send_packet(header_a_t'($urandom), hv, {16'($urandom), 32'($urandom)}, ($urandom_range(0, 4) != 0),
                        header_c_t'($urandom), 1'b1);
            wait_drain();
            compare_model("rand");
        end
        ready_mode = 0;

`ifdef PAYLOAD_PACKER_ERR_EN
        // Test 6: SOP while in BODY raises a sticky error.
        iReset = 1'b1;
        @(posedge iClk);
        #1;
        iReset = 1'b0;
        @(posedge iClk);
        #1;
        checks++;
        assert (oError === 1'b0)
        else begin failures++; $error("FAIL t6_err_clear got=%b exp=0", oError); end
        iHeader_A_valid = 1'b1; iHeader_B_valid = 1'b1; iHeader_C_valid = 1'b1;
        send_beat({8{8'h11}}, 1'b1, 1'b0, 8'hFF);
        send_beat({8{8'h22}}, 1'b0, 1'b0, 8'hFF);
        send_beat({8{8'h33}}, 1'b0, 1'b0, 8'hFF);
        checks++;
        assert (oError === 1'b0)
        else begin failures++; $error("FAIL t6_err_before got=%b exp=0", oError); end
        send_beat({8{8'h44}}, 1'b1, 1'b0, 8'hFF);
        checks++;
        assert (oError === 1'b1)
        else begin failures++; $error("FAIL t6_err_set got=%b exp=1", oError); end
        send_beat({8{8'h55}}, 1'b0, 1'b1, 8'hC0);
        idle_inputs();
        repeat (6) @(posedge iClk);
        #1;
        checks++;
        assert (oError === 1'b1)
        else begin failures++; $error("FAIL t6_err_sticky got=%b exp=1", oError); end
        iReset = 1'b1;
        #1;
        checks++;
        assert (oError === 1'b0)
        else begin failures++; $error("FAIL t6_err_reset got=%b exp=0", oError); end
        @(posedge iClk);
        #1;
        iReset = 1'b0;
        got_q = {};
        exp_q = {};
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
